y86_fetch: RTL and testbench
============================

Y86_FETCH -- requirements
Module: y86_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded at reset.
REQ-002 Parameter IMEM_BYTES, default 1024: size of the instruction memory in bytes; PC+length beyond it is an address error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hold PC and all outputs this cycle.
REQ-006 redirect  input  1  load PC from redirect_pc (branch mispredict or ret).
REQ-007 redirect_pc  input  64  redirect target address.
REQ-008 imem_addr  output  64  combinational, equals current PC.
REQ-009 imem_data  input  80  bytes PC..PC+9, byte PC in bits [7:0], combinational read.
REQ-010 icode, ifun, rA, rB  output  4 each  registered decoded fields; these feed the execute stage's icode/ifun.
REQ-011 valC  output  64  registered constant; valP  output  64  registered PC+length.
REQ-012 f_valid  output  1  registered, outputs hold a fetched instruction.
REQ-013 stat  output  2  registered status: 0 AOK, 1 HLT, 2 ADR, 3 INS.

Function
REQ-014 Byte0 split: icode=[7:4], ifun=[3:0]; byte1 split: rA=[7:4], rB=[3:0]; rA=rB=4'hF when byte1 is absent.
REQ-015 Instruction length: 1 byte for icode 0, 1, 9; 2 for 2, 6, A, B; 9 for 7, 8; 10 for 3, 4, 5.
REQ-016 valC: little-endian bytes 2..9 for icode 3, 4, 5; bytes 1..8 for icode 7, 8; otherwise 0.
REQ-017 valP=PC+length, 64-bit, wrapping modulo 2^64.
REQ-018 Status priority is INS, then ADR, then HLT, then AOK.
REQ-019 INS: icode C..F; ifun>6 for icode 2 or 7; ifun>3 for icode 6; ifun!=0 for any other icode.
REQ-020 ADR: PC+length>IMEM_BYTES, compared with no wrap; INS is evaluated on byte0 only.
REQ-021 HLT: icode 0.
REQ-022 Latency: one cycle; decoded fields register on the edge after PC is presented.
REQ-023 State machine: RUN and HALTED.
REQ-024 RUN to HALTED on the edge that registers stat!=AOK; that edge captures the faulting instruction with f_valid=1.
REQ-025 In HALTED: f_valid=0 from the next edge on, PC and other outputs frozen, stall and redirect ignored; only reset exits.
REQ-026 Next PC in RUN: if redirect, redirect_pc; else if stall, PC unchanged; else predicted PC (REQ-033).
REQ-027 Redirect and stall together: redirect wins; PC loads, outputs hold for the cycle, f_valid forced to 0 (bubble).
REQ-028 Redirect alone: PC loads; outputs register normally except f_valid=0, squashing the wrong-path instruction.
REQ-029 Stall alone: PC and all registered outputs unchanged.

Reset
REQ-030 rst_n low immediately sets PC=RESET_PC, state=RUN, f_valid=0, stat=AOK, icode=1 (nop), ifun=0, rA=rB=4'hF, valC=0, valP=0.
REQ-031 Reset asserted mid-instruction or in HALTED discards all state; the first instruction registers on the first rising edge after release.

Configuration
REQ-032 Macro Y86_BRANCH_PREDICT_EN selects the next-PC prediction.
REQ-033 With Y86_BRANCH_PREDICT_EN defined: predicted PC=valC for icode 7 and 8 (predict taken), valP otherwise. Without it: predicted PC=valP for all icodes; taken jumps and calls rely on redirect.

Verification
REQ-034 Reset release, imem bytes 30 F2 0A 00..00 at PC 0 -> next edge: icode=3, ifun=0, rA=F, rB=2, valC=10, valP=10, stat=AOK, f_valid=1.
REQ-035 Bytes 60 12 at PC 10 -> icode=6, ifun=0, rA=1, rB=2, valP=12; with stall held 3 cycles, all outputs and PC are unchanged for those 3 cycles.
REQ-036 Jump 70 00 01 00..00 at PC 12 -> valC=256, valP=21; next PC is 256 with the macro defined, 21 without it.
REQ-037 Redirect=1 with redirect_pc=64 while stall=1 -> PC becomes 64 and f_valid=0; the instruction at 64 registers on the following edge.
REQ-038 Byte 00 at PC 64 -> stat=HLT, f_valid=1, then f_valid=0 with PC frozen for 5+ cycles despite redirect; byte C0 gives stat=INS; 10-byte instruction at PC 1020 gives stat=ADR.
REQ-039 Assert rst_n low while in HALTED, off a clock edge -> outputs immediately return to REQ-030 values, state RUN, PC=RESET_PC.

Source files
------------

// File: rtl/y86_fetch.sv
// y86_fetch -- Y86-64 instruction fetch stage.
//
// Presents the PC on imem_addr. The memory returns 10 bytes combinationally,
// and the stage decodes them into registered icode/ifun/rA/rB/valC/valP/stat.
// Execution halts on the first instruction whose status is not AOK.
//
// Build option:
//   Y86_BRANCH_PREDICT_EN  when defined, jXX and call are predicted taken
//                          (next PC = valC). Otherwise the next PC is always
//                          valP, and taken control flow arrives via redirect.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   stall                 hold PC and all outputs this cycle
//   redirect, redirect_pc load PC from redirect_pc; squashes the current fetch
//   imem_addr             current PC (combinational)
//   imem_data             bytes PC..PC+9; byte PC is in bits [7:0]
//   icode, ifun, rA, rB   registered decoded fields
//   valC, valP            registered constant word and PC+length
//   f_valid               registered outputs hold a fetched instruction
//   stat                  registered status: 0 AOK, 1 HLT, 2 ADR, 3 INS
module y86_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_data,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        f_valid,
  output logic [1:0]  stat
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // The address limit is compared at 65 bits so that PC+length cannot wrap.
  localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

  logic [0:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic        f_valid_q, f_valid_d;
  logic [1:0]  stat_q, stat_d;

  // Decode of the bytes at the current PC
  logic [3:0]  dec_icode, dec_ifun, dec_ra, dec_rb, dec_len;
  logic        dec_has_reg, dec_ins, dec_adr;
  logic [63:0] dec_valc, dec_valp, pred_pc;
  logic [64:0] dec_end;
  logic [1:0]  dec_stat;

  always_comb begin
    dec_icode   = imem_data[7:4];
    dec_ifun    = imem_data[3:0];
    dec_len     = 4'd1;
    dec_has_reg = 1'b0;
    dec_valc    = 64'h0;
    dec_ins     = 1'b0;
    unique case (dec_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        dec_len     = 4'd2;
        dec_has_reg = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        dec_len     = 4'd10;
        dec_has_reg = 1'b1;
        dec_valc    = imem_data[79:16];
      end
      4'h7, 4'h8: begin
        dec_len  = 4'd9;
        dec_valc = imem_data[71:8];
      end
      default: dec_len = 4'd1;  // halt, nop, ret, and undefined icodes
    endcase

    unique case (dec_icode)
      4'h2, 4'h7:               dec_ins = (dec_ifun > 4'd6);
      4'h6:                     dec_ins = (dec_ifun > 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF:   dec_ins = 1'b1;
      default:                  dec_ins = (dec_ifun != 4'd0);
    endcase

    dec_ra   = dec_has_reg ? imem_data[15:12] : 4'hF;
    dec_rb   = dec_has_reg ? imem_data[11:8]  : 4'hF;
    dec_valp = pc_q + {60'h0, dec_len};
    dec_end  = {1'b0, pc_q} + {61'h0, dec_len};
    dec_adr  = (dec_end > IMEM_LIMIT);

    if (dec_ins)                 dec_stat = STAT_INS;
    else if (dec_adr)            dec_stat = STAT_ADR;
    else if (dec_icode == 4'h0)  dec_stat = STAT_HLT;
    else                         dec_stat = STAT_AOK;

`ifdef Y86_BRANCH_PREDICT_EN
    pred_pc = (dec_icode == 4'h7 || dec_icode == 4'h8) ? dec_valc : dec_valp;
`else
    pred_pc = dec_valp;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    valc_d    = valc_q;
    valp_d    = valp_q;
    f_valid_d = f_valid_q;
    stat_d    = stat_q;

    if (state_q == S_HALTED) begin
      // Frozen until reset. Only f_valid drops.
      f_valid_d = 1'b0;
    end else if (redirect) begin
      pc_d      = redirect_pc;
      f_valid_d = 1'b0;
      // Redirect alone still registers the wrong-path fields, marked invalid.
      // A squashed instruction never halts the machine.
      if (!stall) begin
        icode_d = dec_icode;
        ifun_d  = dec_ifun;
        ra_d    = dec_ra;
        rb_d    = dec_rb;
        valc_d  = dec_valc;
        valp_d  = dec_valp;
        stat_d  = dec_stat;
      end
    end else if (!stall) begin
      icode_d   = dec_icode;
      ifun_d    = dec_ifun;
      ra_d      = dec_ra;
      rb_d      = dec_rb;
      valc_d    = dec_valc;
      valp_d    = dec_valp;
      stat_d    = dec_stat;
      f_valid_d = 1'b1;
      pc_d      = pred_pc;
      if (dec_stat != STAT_AOK) state_d = S_HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      icode_q   <= 4'h1;
      ifun_q    <= 4'h0;
      ra_q      <= 4'hF;
      rb_q      <= 4'hF;
      valc_q    <= 64'h0;
      valp_q    <= 64'h0;
      f_valid_q <= 1'b0;
      stat_q    <= STAT_AOK;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      valc_q    <= valc_d;
      valp_q    <= valp_d;
      f_valid_q <= f_valid_d;
      stat_q    <= stat_d;
    end
  end

  assign imem_addr = pc_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign f_valid   = f_valid_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_y86_fetch.sv
// tb_y86_fetch -- self-checking bench for y86_fetch.
// The bench runs directed scenarios first and then randomized episodes.
// It checks all of them against a table-driven instruction model.
module tb_y86_fetch;

  localparam int IMEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        f_valid;
  logic [1:0]  stat;

  y86_fetch #(.RESET_PC(64'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .f_valid(f_valid), .stat(stat)
  );

  always #5 clk = ~clk;

  // Backing store, 2 KiB, indexed modulo its size
  logic [2047:0][7:0] mem;

  always_comb begin
    imem_data = '0;
    for (int k = 0; k < 10; k++)
      imem_data[8*k +: 8] = mem[(int'(imem_addr[10:0]) + k) % 2048];
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, npc;
    logic [1:0]  stat;
  } dec_t;

  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int fmax_tab[16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0};

  function automatic dec_t decode(input logic [63:0] pc);
    dec_t d;
    logic [7:0] b[10];
    int len, start;
    logic ins, adr;
    for (int k = 0; k < 10; k++) b[k] = mem[(int'(pc[10:0]) + k) % 2048];
    d.icode = b[0][7:4];
    d.ifun  = b[0][3:0];
    len = len_tab[d.icode];
    if (d.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      d.ra = b[1][7:4];
      d.rb = b[1][3:0];
    end else begin
      d.ra = 4'hF;
      d.rb = 4'hF;
    end
    start = (d.icode inside {4'h3, 4'h4, 4'h5}) ? 2 :
            (d.icode inside {4'h7, 4'h8}) ? 1 : -1;
    d.valc = 64'h0;
    if (start >= 0)
      for (int k = 0; k < 8; k++) d.valc = d.valc | (64'(b[start + k]) << (8 * k));
    d.valp = pc + 64'(len);
    ins = (d.icode >= 4'hC) || (int'(d.ifun) > fmax_tab[d.icode]);
    adr = (pc > 64'(IMEM_BYTES)) || (64'(IMEM_BYTES) - pc < 64'(len));
    d.stat = ins ? 2'd3 : adr ? 2'd2 : (d.icode == 4'h0) ? 2'd1 : 2'd0;
`ifdef Y86_BRANCH_PREDICT_EN
    d.npc = (d.icode inside {4'h7, 4'h8}) ? d.valc : d.valp;
`else
    d.npc = d.valp;
`endif
    return d;
  endfunction

  logic [63:0] m_pc, m_valc, m_valp;
  logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
  logic [1:0]  m_stat;
  logic        m_fv, m_halt;

  function automatic void model_reset();
    m_pc = 64'h0; m_halt = 1'b0; m_fv = 1'b0; m_stat = 2'd0;
    m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
    m_valc = 64'h0; m_valp = 64'h0;
  endfunction

  function automatic void model_load(input dec_t d);
    m_icode = d.icode; m_ifun = d.ifun; m_ra = d.ra; m_rb = d.rb;
    m_valc = d.valc; m_valp = d.valp; m_stat = d.stat;
  endfunction

  function automatic void model_step(input logic st, input logic rd, input logic [63:0] rpc);
    dec_t d;
    d = decode(m_pc);
    if (m_halt) m_fv = 1'b0;
    else if (rd) begin
      if (!st) model_load(d);
      m_fv = 1'b0;
      m_pc = rpc;
    end else if (!st) begin
      model_load(d);
      m_fv = 1'b1;
      m_pc = d.npc;
      if (d.stat != 2'd0) m_halt = 1'b1;
    end
  endfunction

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc",      imem_addr, m_pc);
    chk("icode",   64'(icode), 64'(m_icode));
    chk("ifun",    64'(ifun),  64'(m_ifun));
    chk("rA",      64'(rA),    64'(m_ra));
    chk("rB",      64'(rB),    64'(m_rb));
    chk("valC",    valC, m_valc);
    chk("valP",    valP, m_valp);
    chk("f_valid", 64'(f_valid), 64'(m_fv));
    chk("stat",    64'(stat),  64'(m_stat));
  endtask

  // Called between posedge+1 and the next posedge. Applies one cycle of
  // inputs and then checks outputs just after the edge.
  task automatic cycle(input logic st, input logic rd, input logic [63:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    model_step(st, rd, rpc);
    @(posedge clk); #1;
    check_all();
  endtask

  // Asserts reset off the clock edge and checks it takes effect at once.
  // Releases reset at the following negedge.
  task automatic do_reset();
    #2;
    stall = 1'b0; redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] good [16] = '{8'h10, 8'h20, 8'h21, 8'h26, 8'h30, 8'h40, 8'h50, 8'h60,
                              8'h63, 8'h70, 8'h73, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'h00};
    if ($urandom_range(0, 3) != 0) return good[$urandom_range(0, 15)];
    return 8'($urandom);
  endfunction

  task automatic put(input int addr, input logic [79:0] bytes_le, input int n);
    for (int k = 0; k < n; k++) mem[addr + k] = bytes_le[8*k +: 8];
  endtask

  logic [63:0] exp_npc, frozen_pc;

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h10;
    put(0,    80'h0000_0000_0000_000A_F230, 10);
    put(10,   80'h1260, 2);
    put(12,   80'h00_0000_0000_0000_0100_70, 9);
    mem[64]  = 8'h00;
    mem[512] = 8'hC0;
    put(1020, 80'h1122_3344_5566_7788_F230, 10);

    // Reset asserted asynchronously before any clock edge
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_icode", 64'(icode), 64'h1);
    chk("rst_rA",    64'(rA),    64'hF);
    chk("rst_rB",    64'(rB),    64'hF);
    chk("rst_fv",    64'(f_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq $10, %rdx at PC 0
    cycle(1'b0, 1'b0, 64'h0);
    chk("i0_icode", 64'(icode), 64'h3);
    chk("i0_rA",    64'(rA),    64'hF);
    chk("i0_rB",    64'(rB),    64'h2);
    chk("i0_valC",  valC, 64'd10);
    chk("i0_valP",  valP, 64'd10);
    chk("i0_fv",    64'(f_valid), 64'h1);
    chk("i0_stat",  64'(stat), 64'h0);

    // addq at PC 10, then a 3-cycle stall
    cycle(1'b0, 1'b0, 64'h0);
    chk("i1_icode", 64'(icode), 64'h6);
    chk("i1_rA",    64'(rA),    64'h1);
    chk("i1_valP",  valP, 64'd12);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, 1'b0, 64'h0);
      chk("stall_pc",    imem_addr, 64'd12);
      chk("stall_icode", 64'(icode), 64'h6);
      chk("stall_valP",  valP, 64'd12);
      chk("stall_fv",    64'(f_valid), 64'h1);
    end

    // jmp 256 at PC 12
    cycle(1'b0, 1'b0, 64'h0);
`ifdef Y86_BRANCH_PREDICT_EN
    exp_npc = 64'd256;
`else
    exp_npc = 64'd21;
`endif
    chk("jmp_valC", valC, 64'd256);
    chk("jmp_valP", valP, 64'd21);
    chk("jmp_npc",  imem_addr, exp_npc);

    // Redirect during a stall: a bubble, with the PC loaded
    cycle(1'b1, 1'b1, 64'd64);
    chk("rdst_pc",    imem_addr, 64'd64);
    chk("rdst_fv",    64'(f_valid), 64'h0);
    chk("rdst_icode", 64'(icode), 64'h7);

    // halt at PC 64
    cycle(1'b0, 1'b0, 64'h0);
    chk("hlt_stat", 64'(stat), 64'h1);
    chk("hlt_fv",   64'(f_valid), 64'h1);
    frozen_pc = imem_addr;
    for (int s = 0; s < 6; s++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, 64'($urandom));
      chk("halted_fv", 64'(f_valid), 64'h0);
      chk("halted_pc", imem_addr, frozen_pc);
    end
    do_reset();
    chk("hrst_pc", imem_addr, 64'h0);

    // Redirect alone to PC 512 (byte C0): the INS status
    cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 64'd512);
    chk("sq_fv", 64'(f_valid), 64'h0);
    cycle(1'b0, 1'b0, 64'h0);
    chk("ins_stat", 64'(stat), 64'h3);
    chk("ins_fv",   64'(f_valid), 64'h1);
    do_reset();

    // A 10-byte instruction at PC 1020: the ADR status
    cycle(1'b0, 1'b1, 64'd1020);
    cycle(1'b0, 1'b0, 64'h0);
    chk("adr_stat", 64'(stat), 64'h2);
    chk("adr_valP", valP, 64'd1030);
    do_reset();

    // Randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      int halted_cnt;
      for (int a = 0; a < 2048; a++) mem[a] = rand_byte();
      do_reset();
      halted_cnt = 0;
      for (int c = 0; c < 40 && halted_cnt < 4; c++) begin
        logic st, rd;
        logic [63:0] rpc;
        dec_t d;
        st = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 7))
          0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
          1:       rpc = 64'($urandom_range(1010, 1023));
          default: rpc = 64'($urandom_range(0, 1100));
        endcase
        // Never squash a faulting fetch with a bare redirect; pair it with stall.
        d = decode(m_pc);
        if (rd && !st && !m_halt && d.stat != 2'd0) st = 1'b1;
        if ($urandom_range(0, 59) == 0) begin
          do_reset();
          halted_cnt = 0;
        end else begin
          cycle(st, rd, rpc);
          if (m_halt) halted_cnt++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
